// File: rtl/mips_mem_responder_pkg.sv
// Purpose: shared types, constants and address checking for the MIPS data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned WORD_SHIFT    = 2;
  localparam logic [31:0] BAD_READ_DATA = 32'h0000_0000;

  // True when addr is word-aligned and falls inside [base, base + 4*2^aw).
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int unsigned aw);
    logic [32:0] span;
    logic [32:0] off;
    span = 33'(WORD_BYTES) << aw;
    off  = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Purpose: bundles the core-to-data-memory request/response signals.
// Latency: n/a (wires only).
// Backpressure: stall_o from the responder freezes the core while a request is outstanding.
interface mips_mem_responder_if;
  logic [31:0] memoryAddress_i;
  logic        memoryRead_i;
  logic        memoryWrite_i;
  logic [31:0] memoryWriteData_i;
  logic [31:0] memoryReadData_o;
  logic        stall_o;
  logic        error_o;

  // Core side drives requests and observes stall/data/error.
  modport master (
    output memoryAddress_i, memoryRead_i, memoryWrite_i, memoryWriteData_i,
    input  memoryReadData_o, stall_o, error_o
  );

  // Memory side consumes requests and produces stall/data/error.
  modport slave (
    input  memoryAddress_i, memoryRead_i, memoryWrite_i, memoryWriteData_i,
    output memoryReadData_o, stall_o, error_o
  );
endinterface

// File: rtl/mips_mem_array.sv
// Purpose: single-port 2^ADDR_WIDTH x 32 RAM, synchronous write, read follows the address.
// Latency: write lands on the clock edge; read data is combinational from addr_i.
// Backpressure: none; always accepts.
module mips_mem_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Storage has no reset so contents survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_mem_responder.sv
// Purpose: wait-state data-memory responder for the single-cycle MIPS core, owns the RAM.
// Latency: stall_o high for WAIT_STATES+1 cycles per access; read data valid in the DONE cycle.
// Backpressure: stall_o = request & not DONE, so the core holds its request until DONE.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  mips_mem_responder_if.slave bus
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  conflict_q, conflict_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req;
  logic [31:0]           acc_addr;
  logic                  acc_wr;
  logic                  acc_conflict;
  logic                  acc_ok;
  logic                  done_entry;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           ram_rdata;

  assign req         = bus.memoryRead_i | bus.memoryWrite_i;
  assign bus.stall_o = req & (state_q != DONE);

  // In IDLE the access is still on the inputs (zero-wait case enters DONE straight away);
  // afterwards only the latched copy matters, so inputs can move without effect.
  assign acc_addr     = (state_q == IDLE) ? bus.memoryAddress_i : addr_q;
  assign acc_wr       = (state_q == IDLE) ? bus.memoryWrite_i : wr_q;
  assign acc_conflict = (state_q == IDLE) ? (bus.memoryRead_i & bus.memoryWrite_i) : conflict_q;
  assign acc_ok       = addr_ok(acc_addr, BASE_ADDR, ADDR_WIDTH);
  assign word_idx     = ADDR_WIDTH'((acc_addr - BASE_ADDR) >> WORD_SHIFT);

  // Writes commit on the edge that leaves DONE; bad addresses are silently dropped.
  assign ram_we = (state_q == DONE) & wr_q & acc_ok;

  mips_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (word_idx),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  // Next state, wait counter and request latching.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    conflict_d = conflict_q;
    done_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d     = bus.memoryAddress_i;
          wdata_d    = bus.memoryWriteData_i;
          wr_d       = bus.memoryWrite_i;
          conflict_d = bus.memoryRead_i & bus.memoryWrite_i;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d    = DONE;
            done_entry = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          done_entry = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data and sticky error are both resolved on the edge entering DONE.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (done_entry) begin
      if (!acc_wr) begin
        rdata_d = acc_ok ? ram_rdata : BAD_READ_DATA;
      end
      if (!acc_ok || acc_conflict) begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers; RAM contents are deliberately left alone by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.memoryReadData_o = rdata_q;
  assign bus.error_o          = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Purpose: directed scoreboard bench for mips_mem_responder with 2 and 0 wait states.
// Latency: checks stall length, DONE-cycle read data and sticky error per access.
// Backpressure: each access holds its request until stall_o drops, as the core would.
module tb_mips_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mips_mem_responder_if bus2 ();
  mips_mem_responder_if bus0 ();

  mips_mem_responder #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(2),
    .BASE_ADDR  (32'h0000_0000)
  ) dut2 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus2)
  );

  mips_mem_responder #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(0),
    .BASE_ADDR  (32'h0000_0000)
  ) dut0 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: sel 0 = two-wait-state instance, sel 1 = zero-wait-state instance.
  logic [31:0] mem_m [int];
  logic [31:0] held_m [2];
  logic        err_m [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus0.memoryRead_i      = rd;
      bus0.memoryWrite_i     = wr;
      bus0.memoryAddress_i   = addr;
      bus0.memoryWriteData_i = wdata;
    end else begin
      bus2.memoryRead_i      = rd;
      bus2.memoryWrite_i     = wr;
      bus2.memoryAddress_i   = addr;
      bus2.memoryWriteData_i = wdata;
    end
  endtask

  function automatic logic get_stall(input bit sel);
    return sel ? bus0.stall_o : bus2.stall_o;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus0.memoryReadData_o : bus2.memoryReadData_o;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus0.error_o : bus2.error_o;
  endfunction

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    exp_t e;
    exp_t got;
    bit   good;
    int   key;
    int   n;
    good = (addr[1:0] == 2'b00) && (addr < 32'h0000_1000);
    key  = good ? (int'(sel) * 1024 + int'(addr >> 2)) : 0;
    if (wr) begin
      if (good) mem_m[key] = wdata;
    end else begin
      held_m[sel] = (good && mem_m.exists(key)) ? mem_m[key] : 32'h0;
    end
    if (!good || (rd && wr)) err_m[sel] = 1'b1;
    e.rdata  = held_m[sel];
    e.err    = err_m[sel];
    e.stalls = (sel ? 0 : 2) + 1;
    e.tag    = tag;
    exp_q.push_back(e);

    drive(sel, rd, wr, addr, wdata);
    n = 0;
    @(negedge clk);
    while (get_stall(sel) === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    got = exp_q.pop_front();
    chk({got.tag, "_stalls"}, 32'(n), 32'(got.stalls));
    chk({got.tag, "_rdata"}, get_rdata(sel), got.rdata);
    chk({got.tag, "_err"}, 32'(get_err(sel)), 32'(got.err));
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    held_m[0] = 32'h0;
    held_m[1] = 32'h0;
    err_m[0]  = 1'b0;
    err_m[1]  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_stall2", 32'(bus2.stall_o), 32'h0);
    chk("rst_rdata2", bus2.memoryReadData_o, 32'h0);
    chk("rst_err2", 32'(bus2.error_o), 32'h0);
    chk("rst_stall0", 32'(bus0.stall_o), 32'h0);
    chk("rst_rdata0", bus0.memoryReadData_o, 32'h0);
    chk("rst_err0", 32'(bus0.error_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two wait states: basic read/write path.
    access(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, "rd00");
    access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, "wr10");
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd10");
    access(1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_0030, "wr30");

    // Bad addresses complete normally, read zero and latch the error.
    access(1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0, "rd_misaligned");
    access(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, "rd_out_of_range");
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd10_sticky");

    // Read and write together behave as a write and flag an error.
    access(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, "rw20");
    access(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, "rd20");

    // Reset in the middle of a write's wait phase must abort it.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chk("abort_wait_stall", 32'(bus2.stall_o), 32'h1);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    held_m[0] = 32'h0;
    held_m[1] = 32'h0;
    err_m[0]  = 1'b0;
    err_m[1]  = 1'b0;
    #1;
    chk("abort_stall", 32'(bus2.stall_o), 32'h0);
    chk("abort_rdata", bus2.memoryReadData_o, 32'h0);
    chk("abort_err", 32'(bus2.error_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    access(1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, "rd30_after_rst");

    // Zero wait states: preload then back-to-back reads.
    access(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, "z_wr00");
    access(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, "z_wr04");
    access(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, "z_wr08");
    access(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, "z_rd00");
    access(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, "z_rd04");
    access(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, "z_rd08");
    access(1'b1, 1'b1, 1'b0, 32'h0000_0ffe, 32'h0, "z_rd_misaligned");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
